// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter for one mesh router output port.
// Grants one requesting input FIFO at a time, moves exactly one packet per
// grant (pop source + push destination) and honours destination backpressure.
// A one-cycle GAP follows every transfer so the source head can refresh.
module mesh_port_arbiter #(
    parameter int NUM_IN    = 5,
    parameter int pckg_sz   = 40,
    parameter int STALL_MAX = 16,
    localparam int IDX_W    = $clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         req,
    input  logic [NUM_IN*pckg_sz-1:0] data_in,
    input  logic                      dst_full,
    output logic                      push,
    output logic [pckg_sz-1:0]        data_out,
    output logic [NUM_IN-1:0]         pop,
    output logic                      gnt_vld,
    output logic [IDX_W-1:0]          gnt_idx,
    output logic [15:0]               pkt_cnt,
    output logic                      stall
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0]       STALL_MAX_C = 8'(STALL_MAX);
    localparam logic [IDX_W:0]   NUM_IN_C    = (IDX_W+1)'(NUM_IN);
    localparam logic [IDX_W-1:0] LAST_IDX_C  = IDX_W'(NUM_IN - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;
    logic             stall_q, stall_d;

    logic [IDX_W-1:0] winner_s;
    logic             found_s;
    logic [IDX_W:0]   cand_s;
    logic             req_gnt_s;
    logic             push_s;
    logic [pckg_sz-1:0] data_s;

    assign req_gnt_s = req[gnt_idx_q];
    assign gnt_vld   = (state_q == ST_SEND);
    // Reset gates the strobes so an in-flight packet stays in its source.
    assign push_s    = reset & gnt_vld & req_gnt_s & ~dst_full;

    assign push     = push_s;
    assign pop      = push_s ? ({{(NUM_IN-1){1'b0}}, 1'b1} << gnt_idx_q) : {NUM_IN{1'b0}};
    assign data_out = data_s;
    assign gnt_idx  = gnt_idx_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign stall    = stall_q;

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        winner_s = ptr_q;
        found_s  = 1'b0;
        cand_s   = {(IDX_W+1){1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            cand_s = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand_s >= NUM_IN_C) begin
                cand_s = cand_s - NUM_IN_C;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDX_W-1:0]]) begin
                winner_s = cand_s[IDX_W-1:0];
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Head-packet mux for the granted source; zero when no grant is active.
    always_comb begin
        data_s = {pckg_sz{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            if (reset && gnt_vld && (gnt_idx_q == IDX_W'(i))) begin
                data_s = data_in[i*pckg_sz +: pckg_sz];
            end else begin
                data_s = data_s;
            end
        end
    end

    // Next-state logic for the IDLE/SEND/GAP grant sequence and counters.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        pkt_cnt_d   = pkt_cnt_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;
        case (state_q)
            ST_IDLE: begin
                stall_cnt_d = 8'd0;
                stall_d     = 1'b0;
                if (found_s) begin
                    gnt_idx_d = winner_s;
                    state_d   = ST_SEND;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!req_gnt_s) begin
                    // Source withdrew: drop the grant, keep the pointer.
                    state_d     = ST_IDLE;
                    stall_cnt_d = 8'd0;
                    stall_d     = 1'b0;
                end else if (!dst_full) begin
                    pkt_cnt_d   = (pkt_cnt_q == 16'hFFFF) ? 16'hFFFF : pkt_cnt_q + 16'd1;
                    ptr_d       = (gnt_idx_q == LAST_IDX_C) ? {IDX_W{1'b0}} : gnt_idx_q + IDX_W'(1);
                    stall_cnt_d = 8'd0;
                    stall_d     = 1'b0;
                    state_d     = ST_GAP;
                end else begin
                    // Blocked: hold the grant and count consecutive stall cycles.
                    stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
                    stall_d     = (stall_cnt_d >= STALL_MAX_C);
                    state_d     = ST_SEND;
                end
            end
            ST_GAP: begin
                stall_cnt_d = 8'd0;
                stall_d     = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                stall_cnt_d = 8'd0;
                stall_d     = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= {IDX_W{1'b0}};
            gnt_idx_q   <= {IDX_W{1'b0}};
            pkt_cnt_q   <= 16'd0;
            stall_cnt_q <= 8'd0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            pkt_cnt_q   <= pkt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

endmodule
